// File: rtl/irig_pulse_classifier.sv
// IRIG pulse-width front end: input conditioning, high-pulse measurement,
// zero/one/mark/error classification, 100-bit frame tracking and loss of signal.
module irig_pulse_classifier #(
  parameter int unsigned CNT_W         = 18,
  parameter int unsigned ZERO_MIN      = 15000,
  parameter int unsigned ONE_MIN       = 45000,
  parameter int unsigned MARK_MIN      = 75000,
  parameter int unsigned MARK_MAX      = 95000,
  parameter int unsigned LOS_CYCLES    = 250000,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned GLITCH_CYCLES = 16,
  parameter int unsigned INVERT        = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             irig_in,
  output logic             sym_valid,
  output logic [1:0]       sym_code,
  output logic [CNT_W-1:0] sym_width,
  output logic             frame_start,
  output logic             locked,
  output logic [6:0]       bit_idx,
  output logic             los
);

  localparam int unsigned GW = $clog2(GLITCH_CYCLES + 1);
  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_ONE  = 2'b01;
  localparam logic [1:0] CODE_MARK = 2'b10;
  localparam logic [1:0] CODE_ERR  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_filt;
  logic                   r_filt_q;
  logic [GW-1:0]          r_gcnt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_los_cnt;
  logic                   r_prev_mark;

  logic                   w_in_c;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic [1:0]             w_code;
  logic                   w_is_mark;
  logic                   w_exp_mark;
  logic                   w_frame;
  logic                   w_los_hit;
  logic [CNT_W-1:0]       w_los_nxt;
  logic [6:0]             w_idx_nxt;

  assign w_in_c = irig_in ^ 1'(INVERT);
  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = r_filt & ~r_filt_q;
  assign w_fall = ~r_filt & r_filt_q;

  // Synchroniser and symmetric glitch filter: both edges are delayed equally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_filt   <= 1'b0;
      r_filt_q <= 1'b0;
      r_gcnt   <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], w_in_c};
      r_filt_q <= r_filt;
      if (w_s == r_filt) begin
        r_gcnt <= '0;
      end else if (r_gcnt == GW'(GLITCH_CYCLES - 1)) begin
        r_filt <= w_s;
        r_gcnt <= '0;
      end else begin
        r_gcnt <= r_gcnt + GW'(1);
      end
    end
  end

  // High-width counter; holds the exact high length in the cycle fall is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= CNT_W'(1);
    end else if (r_filt && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_code = CODE_ERR;
    if (r_cnt >= CNT_W'(ZERO_MIN) && r_cnt < CNT_W'(ONE_MIN)) begin
      w_code = CODE_ZERO;
    end else if (r_cnt >= CNT_W'(ONE_MIN) && r_cnt < CNT_W'(MARK_MIN)) begin
      w_code = CODE_ONE;
    end else if (r_cnt >= CNT_W'(MARK_MIN) && r_cnt <= CNT_W'(MARK_MAX)) begin
      w_code = CODE_MARK;
    end
  end

  assign w_los_nxt  = w_rise ? '0 :
                      (r_los_cnt == CNT_MAX) ? r_los_cnt : r_los_cnt + CNT_W'(1);
  assign w_los_hit  = ~w_rise & (w_los_nxt == CNT_W'(LOS_CYCLES));
  assign w_is_mark  = (w_code == CODE_MARK);
  assign w_idx_nxt  = (bit_idx == 7'd99) ? 7'd0 : bit_idx + 7'd1;
  assign w_exp_mark = (7'(w_idx_nxt % 7'd10) == 7'd9);
  // LOS in the same cycle suppresses frame alignment.
  assign w_frame    = w_fall & w_is_mark & r_prev_mark & ~w_los_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_los_cnt   <= '0;
      r_prev_mark <= 1'b0;
      sym_valid   <= 1'b0;
      sym_code    <= CODE_ZERO;
      sym_width   <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      bit_idx     <= '0;
      los         <= 1'b0;
    end else begin
      r_los_cnt   <= w_los_nxt;
      sym_valid   <= w_fall;
      frame_start <= w_frame;
      if (w_fall) begin
        sym_code  <= w_code;
        sym_width <= r_cnt;
        if (w_frame) begin
          bit_idx     <= 7'd0;
          locked      <= 1'b1;
          r_prev_mark <= 1'b0;
        end else begin
          bit_idx     <= w_idx_nxt;
          r_prev_mark <= w_is_mark;
          if ((w_code == CODE_ERR) || (w_is_mark != w_exp_mark)) begin
            locked <= 1'b0;
          end
        end
      end
      if (w_los_hit) begin
        los         <= 1'b1;
        locked      <= 1'b0;
        r_prev_mark <= 1'b0;
      end else if (w_rise) begin
        los <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_irig_pulse_classifier.sv
// Randomised bench for irig_pulse_classifier with a symbol-level reference model
// (pulse widths in, expected symbol/frame state out), using scaled-down widths.
module tb_irig_pulse_classifier;

  localparam int CW   = 10;
  localparam int ZMIN = 50;
  localparam int OMIN = 100;
  localparam int MMIN = 150;
  localparam int MMAX = 200;
  localparam int LOSC = 500;
  localparam int SYNC = 2;
  localparam int GLT  = 4;
  localparam int LAT  = SYNC + GLT;
  localparam int CMAX = (1 << CW) - 1;
  localparam int W_ZERO = 70;
  localparam int W_ONE  = 120;
  localparam int W_MARK = 170;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          irig_in = 1'b0;
  logic          sym_valid;
  logic [1:0]    sym_code;
  logic [CW-1:0] sym_width;
  logic          frame_start;
  logic          locked;
  logic [6:0]    bit_idx;
  logic          los;

  irig_pulse_classifier #(
    .CNT_W(CW), .ZERO_MIN(ZMIN), .ONE_MIN(OMIN), .MARK_MIN(MMIN), .MARK_MAX(MMAX),
    .LOS_CYCLES(LOSC), .SYNC_STAGES(SYNC), .GLITCH_CYCLES(GLT), .INVERT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irig_in(irig_in),
    .sym_valid(sym_valid), .sym_code(sym_code), .sym_width(sym_width),
    .frame_start(frame_start), .locked(locked), .bit_idx(bit_idx), .los(los)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one entry per expected symbol
  typedef struct {
    logic [1:0] code;
    int         width;
    bit         fs;
    bit         lk;
    int         idx;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  bit   m_prev = 0;
  bit   m_lock = 0;
  int   m_idx  = 0;

  function automatic logic [1:0] classify(input int w);
    if (w < ZMIN) return 2'b11;
    if (w < OMIN) return 2'b00;
    if (w < MMIN) return 2'b01;
    if (w <= MMAX) return 2'b10;
    return 2'b11;
  endfunction

  function automatic void model_sym(input int hi);
    exp_t e;
    e.width = (hi > CMAX) ? CMAX : hi;
    e.code  = classify(e.width);
    e.fs    = 0;
    if (e.code == 2'b10 && m_prev) begin
      e.fs = 1; m_idx = 0; m_lock = 1; m_prev = 0;
    end else begin
      m_idx = (m_idx + 1) % 100;
      if (e.code == 2'b11 || ((e.code == 2'b10) != (m_idx % 10 == 9))) m_lock = 0;
      m_prev = (e.code == 2'b10);
    end
    e.lk  = m_lock;
    e.idx = m_idx;
    q.push_back(e);
  endfunction

  function automatic void model_los();
    m_lock = 0;
    m_prev = 0;
  endfunction

  // Symbol monitor: every strobe must match the next model entry
  always @(negedge clk) begin
    if (rst_n) begin
      if (sym_valid) begin
        if (q.size() == 0) begin
          check_eq("spurious_sym_valid", 32'(sym_valid), 32'd0);
        end else begin
          m_e = q.pop_front();
          check_eq("sym_code",    32'(sym_code),    32'(m_e.code));
          check_eq("sym_width",   32'(sym_width),   32'(m_e.width));
          check_eq("frame_start", 32'(frame_start), 32'(m_e.fs));
          check_eq("locked",      32'(locked),      32'(m_e.lk));
          check_eq("bit_idx",     32'(bit_idx),     32'(m_e.idx));
        end
      end
      if (frame_start && !sym_valid) check_eq("fs_without_sv", 32'(frame_start), 32'd0);
    end
  end

  task automatic check_reset(input string tag);
    check_eq({tag, "_sym_valid"},   32'(sym_valid),   32'd0);
    check_eq({tag, "_sym_code"},    32'(sym_code),    32'd0);
    check_eq({tag, "_sym_width"},   32'(sym_width),   32'd0);
    check_eq({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check_eq({tag, "_locked"},      32'(locked),      32'd0);
    check_eq({tag, "_bit_idx"},     32'(bit_idx),     32'd0);
    check_eq({tag, "_los"},         32'(los),         32'd0);
  endtask

  // High for hi sampled cycles, then low; effective low is lo+1 before the next pulse
  task automatic pulse(input int hi, input int lo);
    if (hi >= LOSC) model_los();
    model_sym(hi);
    @(negedge clk); irig_in = 1'b1;
    repeat (hi) @(negedge clk);
    irig_in = 1'b0;
    repeat (lo) @(negedge clk);
    if (hi + lo + 1 > LOSC) model_los();
  endtask

  task automatic glitch_pulse(input int a, input int g, input int b, input int lo);
    if (g < GLT) model_sym(a + g + b);
    else begin model_sym(a); model_sym(b); end
    @(negedge clk); irig_in = 1'b1;
    repeat (a) @(negedge clk);
    irig_in = 1'b0;
    repeat (g) @(negedge clk);
    irig_in = 1'b1;
    repeat (b) @(negedge clk);
    irig_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_frame(input bit drop_p1);
    for (int i = 0; i < 100; i++) begin
      if (i == 0 || (i % 10 == 9 && !(drop_p1 && i == 9))) pulse(W_MARK, 30);
      else if (i == 9) pulse(W_ZERO, 30);
      else pulse(($urandom_range(0, 1) != 0) ? W_ONE : W_ZERO, 30);
    end
  endtask

  int bnd_w[8] = '{49, 50, 99, 100, 149, 150, 200, 201};
  int e_rise;
  int held;

  initial begin
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) pulse(bnd_w[i], 60);

    glitch_pulse(65, GLT - 1, 65, 60);
    glitch_pulse(65, GLT, 65, 60);

    pulse(W_MARK, 30);
    send_frame(1'b0);
    send_frame(1'b1);
    pulse(W_MARK, 30);

    for (int i = 0; i < 40; i++) pulse($urandom_range(GLT, 260), $urandom_range(GLT, 200));

    // Stuck high: LOS fires while high, the eventual fall is an error
    pulse(1100, 60);
    check_eq("los_after_stuck_high", 32'(los), 32'd1);

    pulse(W_MARK, 30);
    pulse(W_MARK, 30);
    @(negedge clk); irig_in = 1'b1;
    e_rise = cyc + 1;
    model_sym(W_ZERO);
    repeat (W_ZERO) @(negedge clk);
    irig_in = 1'b0;
    while (cyc < e_rise + LOSC + LAT - 1) @(negedge clk);
    check_eq("los_before_timeout", 32'(los), 32'd0);
    check_eq("locked_before_timeout", 32'(locked), 32'd1);
    @(negedge clk);
    check_eq("los_at_timeout", 32'(los), 32'd1);
    check_eq("locked_at_timeout", 32'(locked), 32'd0);
    model_los();

    @(negedge clk); irig_in = 1'b1;
    e_rise = cyc + 1;
    model_sym(W_ONE);
    while (cyc < e_rise + LAT - 1) @(negedge clk);
    check_eq("los_before_rise", 32'(los), 32'd1);
    @(negedge clk);
    check_eq("los_cleared_at_rise", 32'(los), 32'd0);
    held = cyc - e_rise + 1;
    repeat (W_ONE - held) @(negedge clk);
    irig_in = 1'b0;
    repeat (40) @(negedge clk);

    // Reset in the middle of a mark
    check_eq("pending_pre_reset", 32'(q.size()), 32'd0);
    irig_in = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid_rst");
    repeat (2) @(negedge clk);
    check_eq("mid_rst_sym_valid_late", 32'(sym_valid), 32'd0);
    rst_n = 1'b1;
    q.delete();
    m_prev = 0; m_lock = 0; m_idx = 0;
    model_sym(W_ONE);
    repeat (W_ONE) @(negedge clk);
    irig_in = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    check_eq("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irig_pulse_classifier.md
# irig_pulse_classifier

Parametrised IRIG pulse-width front end: conditions the raw IRIG input (polarity, synchroniser, glitch filter), measures each high pulse, and classifies it as zero, one, mark or error. It also tracks the 100-bit frame structure to provide frame start, bit index, lock and loss-of-signal status. It sits between the IRIG input pin and the time-code shift/decode logic.

## Interface
- CNT_W, 18, width of the pulse-width and LOS counters
- ZERO_MIN, 15000, minimum width in clk cycles for a zero
- ONE_MIN, 45000, minimum width for a one
- MARK_MIN, 75000, minimum width for a mark
- MARK_MAX, 95000, maximum width for a mark; anything longer is an error
- LOS_CYCLES, 250000, cycles without a filtered rising edge before LOS; must be < 2^CNT_W
- SYNC_STAGES, 2, synchroniser depth, ≥2
- GLITCH_CYCLES, 16, filter qualification length, ≥1
- INVERT, 0, 1 inverts irig_in before the synchroniser

Ports:
- clk  in  1  system clock (defaults sized for 10 MHz)
- rst_n  in  1  reset; asynchronous assert, active-low
- irig_in  in  1  raw asynchronous IRIG level
- sym_valid  out  1  one-cycle strobe; classified symbol present
- sym_code  out  2  00 zero, 01 one, 10 mark, 11 error; held between strobes
- sym_width  out  CNT_W  measured high width in cycles; held between strobes
- frame_start  out  1  one-cycle strobe, coincident with sym_valid, on the second consecutive mark
- locked  out  1  frame alignment valid
- bit_idx  out  7  index of the last strobed symbol in the frame, 0..99
- los  out  1  loss of signal

## Operation
- Conditioning:
  - in_c = irig_in XOR INVERT.
  - in_c passes through a SYNC_STAGES flop chain to give s.
  - Filter: filt takes the value of s only after s has differed from filt for GLITCH_CYCLES consecutive cycles. Any agreement clears the disagreement count.
  - Both edges see the same delay, so filtered width equals raw width for clean input.
- Edges: filt_q is filt delayed one cycle. Rise = filt & ~filt_q. Fall = ~filt & filt_q.
- Width counter cnt:
  - On rise, cnt ← 1.
  - While filt is high otherwise, cnt ← cnt+1, saturating at all-ones.
  - On fall, cnt equals the exact number of cycles filt was high.
- Classification of cnt on fall:
  - < ZERO_MIN → error
  - [ZERO_MIN, ONE_MIN) → zero
  - [ONE_MIN, MARK_MIN) → one
  - [MARK_MIN, MARK_MAX] → mark
  - > MARK_MAX (including saturated) → error
- On the next cycle after fall: sym_valid=1, sym_code and sym_width are updated.
- Frame tracker (updates in the same cycle as sym_valid):
  - prev_mark is set by a mark and cleared by any other code.
  - A mark with prev_mark=1 asserts frame_start and sets bit_idx=0, locked=1, prev_mark=0.
  - Otherwise, bit_idx ← (bit_idx==99) ? 0 : bit_idx+1.
  - While locked, expected mark positions are bit_idx ∈ {9,19,…,89,99}.
  - locked clears when any of these occur: a mark at a non-expected index, a non-mark at an expected index, an error code, or LOS.
  - With locked=0, bit_idx still counts but carries no meaning.
- LOS:
  - Counter reset on every rise; otherwise increments, saturating.
  - When the count reaches LOS_CYCLES: los=1, locked=0, prev_mark=0.
  - los clears on the next rise.
  - A stuck-high input also triggers LOS; its eventual fall yields an error symbol.

## Timing
- Reset values: sym_valid 0, sym_code 00, sym_width 0, frame_start 0, locked 0, bit_idx 0, los 0. All sync and filter flops are 0 and all counters are 0.
- Latency from the first clk edge that samples the new irig_in level to the sym_valid strobe: SYNC_STAGES + GLITCH_CYCLES + 1 cycles (19 with defaults). Rise-to-counter-start uses the same latency.
- Back-to-back pulses: the minimum spacing is set by the filter; no symbol is lost as long as high and low phases are each ≥ GLITCH_CYCLES.
- Simultaneous LOS assertion and sym_valid: the symbol is still emitted and locked clears (LOS wins). frame_start is suppressed in that cycle.
- rst_n asserted mid-pulse clears everything immediately. After release, a pulse already in progress is treated as starting at the first filtered rise.

## Test plan
- Clean frame at 10 MHz: a full 100-bit frame of 2/5/8 ms pulses preceded by P0 → codes 00/01/10 match the pattern; frame_start on Pr; locked=1; bit_idx wraps 99→0; sym_width = 20000/50000/80000.
- Width boundaries: highs of 14999, 15000, 44999, 45000, 74999, 75000, 95000, 95001 cycles → codes 11, 00, 00, 01, 01, 10, 10, 11.
- Glitch filtering: a 15-cycle low inside a 5 ms high → single one-symbol with sym_width 50000. A 16-cycle low → two symbols.
- Lock loss: in a locked stream, replace P1 (bit_idx 9) with a zero → locked falls in that sym_valid cycle. The next two consecutive marks → relocks with frame_start.
- LOS: stop pulses → los=1 and locked=0 exactly LOS_CYCLES+latency after the last raw rise. The next pulse clears los at the filtered rise.
- Reset mid-pulse: assert rst_n low for 3 cycles during a mark → all outputs read reset values during reset. No spurious sym_valid for the truncated pulse unless it later meets the width rules.
